// File: rtl/in_port_unit_if.sv
// Input-port bundle: external device push side plus bus/control side.
// The device/bench drives as master; the port unit is the slave.
interface in_port_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ext_data;
    logic             ext_valid;
    logic             ext_ready;
    logic             In_port_out;
    logic [WIDTH-1:0] in_port_data_out;
    logic             data_avail;
    logic             underflow;
    logic             err_clear;

    modport master (
        output ext_data,
        output ext_valid,
        output In_port_out,
        output err_clear,
        input  ext_ready,
        input  in_port_data_out,
        input  data_avail,
        input  underflow
    );

    modport slave (
        input  ext_data,
        input  ext_valid,
        input  In_port_out,
        input  err_clear,
        output ext_ready,
        output in_port_data_out,
        output data_avail,
        output underflow
    );
endinterface

// File: rtl/in_port_unit.sv
// Input port: small FIFO fed by an external valid/ready source.
// One word retires per In_port_out assertion, however long it is held.
module in_port_unit #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          clr,
    in_port_unit_if.slave io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_hold_q, rd_hold_d;
    logic             was_empty_q, was_empty_d;
    logic             underflow_q, underflow_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             start;
    logic [WIDTH-1:0] head;

    // Occupancy flags and the handshake/read events of this cycle.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        head  = empty ? '0 : mem[rd_ptr_q];
        push  = io.ext_valid && !full;
        start = (state_q == IDLE) && io.In_port_out;
        // A read that began on an empty FIFO has nothing to retire.
        pop   = (state_q == READ) && !io.In_port_out && !was_empty_q;
    end

    // Next-state for the read FSM, pointers, count and sticky error.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_hold_d   = rd_hold_q;
        was_empty_d = was_empty_q;
        underflow_d = underflow_q;

        unique case (state_q)
            IDLE: begin
                if (io.In_port_out) begin
                    state_d     = READ;
                    rd_hold_d   = head;
                    was_empty_d = empty;
                end
            end
            READ: begin
                if (!io.In_port_out) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        // A new empty read outranks a simultaneous clear.
        if (start && empty) begin
            underflow_d = 1'b1;
        end else if (io.err_clear) begin
            underflow_d = 1'b0;
        end
    end

    // Control state; storage contents survive reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_hold_q   <= '0;
            was_empty_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_hold_q   <= rd_hold_d;
            was_empty_q <= was_empty_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= io.ext_data;
        end
    end

    // Bus word: held snapshot in READ, live head on the first cycle.
    always_comb begin
        io.ext_ready  = !full;
        io.data_avail = !empty;
        io.underflow  = underflow_q;
        if (state_q == READ) begin
            io.in_port_data_out = rd_hold_q;
        end else if (io.In_port_out) begin
            io.in_port_data_out = head;
        end else begin
            io.in_port_data_out = '0;
        end
    end
endmodule

// File: tb/tb_in_port_unit.sv
// Bench for in_port_unit: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_in_port_unit;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    in_port_unit_if #(.WIDTH(WIDTH)) pif ();

    in_port_unit #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .clr(clr),
        .io (pif)
    );

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          r;
        bit          e;
        bit          x_ready;
        bit          x_avail;
        bit          x_uf;
        logic [31:0] x_bus;
    } vec_t;

    vec_t tbl[28];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: a word queue plus the state of the current read.
    logic [31:0] mq[$];
    bit          m_rd;
    bit          m_we;
    bit          m_uf;
    logic [31:0] m_hold;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input bit v, input logic [31:0] d,
                         input bit r, input bit e);
        pif.ext_valid   = v;
        pif.ext_data    = d;
        pif.In_port_out = r;
        pif.err_clear   = e;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd   = 0;
        m_we   = 0;
        m_uf   = 0;
        m_hold = '0;
    endtask

    function automatic logic [31:0] m_bus();
        if (m_rd) return m_hold;
        if (pif.In_port_out) return (mq.size() != 0) ? mq[0] : 32'h0;
        return 32'h0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".ready"}, 32'(pif.ext_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".avail"}, 32'(pif.data_avail), 32'(mq.size() != 0));
        chk({tag, ".uf"}, 32'(pif.underflow), 32'(m_uf));
        chk({tag, ".bus"}, pif.in_port_data_out, m_bus());
    endtask

    // Apply one clock edge to the model using the inputs held now.
    task automatic model_edge();
        bit push;
        bit pop;
        bit set;
        push = pif.ext_valid && (mq.size() < DEPTH);
        pop  = 0;
        set  = 0;
        if (!m_rd && pif.In_port_out) begin
            m_rd   = 1;
            m_we   = (mq.size() == 0);
            m_hold = m_we ? 32'h0 : mq[0];
            set    = m_we;
        end else if (m_rd && !pif.In_port_out) begin
            m_rd = 0;
            pop  = !m_we;
        end
        if (set) m_uf = 1;
        else if (pif.err_clear) m_uf = 0;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(pif.ext_data);
    endtask

    task automatic cyc(input bit v, input logic [31:0] d, input bit r,
                       input bit e, input string tag);
        drive(v, d, r, e);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [31:0] w[6];

        tbl = '{
            '{1, 32'hA5, 0, 0, 1, 0, 0, 32'h0},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'hA5},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'hA5},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'hA5},
            '{0, 32'h0,  0, 0, 1, 1, 0, 32'hA5},
            '{1, 32'h11, 0, 0, 1, 0, 0, 32'h0},
            '{1, 32'h22, 0, 0, 1, 1, 0, 32'h0},
            '{1, 32'h33, 0, 0, 1, 1, 0, 32'h0},
            '{1, 32'h44, 0, 0, 1, 1, 0, 32'h0},
            '{1, 32'h55, 0, 0, 0, 1, 0, 32'h0},
            '{0, 32'h0,  1, 0, 0, 1, 0, 32'h11},
            '{0, 32'h0,  0, 0, 0, 1, 0, 32'h11},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'h22},
            '{0, 32'h0,  0, 0, 1, 1, 0, 32'h22},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'h33},
            '{0, 32'h0,  0, 0, 1, 1, 0, 32'h33},
            '{0, 32'h0,  1, 0, 1, 1, 0, 32'h44},
            '{0, 32'h0,  0, 0, 1, 1, 0, 32'h44},
            '{0, 32'h0,  0, 0, 1, 0, 0, 32'h0},
            '{0, 32'h0,  1, 0, 1, 0, 0, 32'h0},
            '{0, 32'h0,  0, 0, 1, 0, 1, 32'h0},
            '{0, 32'h0,  0, 0, 1, 0, 1, 32'h0},
            '{0, 32'h0,  0, 1, 1, 0, 1, 32'h0},
            '{0, 32'h0,  0, 0, 1, 0, 0, 32'h0},
            '{0, 32'h0,  1, 1, 1, 0, 0, 32'h0},
            '{0, 32'h0,  0, 0, 1, 0, 1, 32'h0},
            '{0, 32'h0,  0, 1, 1, 0, 1, 32'h0},
            '{0, 32'h0,  0, 0, 1, 0, 0, 32'h0}
        };

        // Reset held for two cycles.
        clr = 1'b1;
        drive(0, '0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(pif.ext_ready), 32'h1);
        chk("rst.avail", 32'(pif.data_avail), 32'h0);
        chk("rst.uf", 32'(pif.underflow), 32'h0);
        chk("rst.bus", pif.in_port_data_out, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: single read, fill/overflow, ordered drain,
        // empty read with underflow and clear priority.
        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].e);
            @(negedge clk);
            chk($sformatf("tbl%0d.ready", i), 32'(pif.ext_ready),
                32'(tbl[i].x_ready));
            chk($sformatf("tbl%0d.avail", i), 32'(pif.data_avail),
                32'(tbl[i].x_avail));
            chk($sformatf("tbl%0d.uf", i), 32'(pif.underflow),
                32'(tbl[i].x_uf));
            chk($sformatf("tbl%0d.bus", i), pif.in_port_data_out,
                tbl[i].x_bus);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Pointer wrap with interleaved push and read.
        for (int i = 0; i < 6; i++) w[i] = 32'hA000_0000 + 32'(i * 7 + 1);
        cyc(1, w[0], 0, 0, "wrap.p0");
        for (int i = 1; i < 6; i++) begin
            drive(1, w[i], 1, 0);
            @(negedge clk);
            chk($sformatf("wrap%0d.bus", i), pif.in_port_data_out, w[i-1]);
            check_model("wrap");
            @(posedge clk);
            model_edge();
            #1;
            cyc(0, '0, 0, 0, "wrap.end");
        end
        drive(0, '0, 1, 0);
        @(negedge clk);
        chk("wrap5.bus", pif.in_port_data_out, w[5]);
        @(posedge clk);
        model_edge();
        #1;
        cyc(0, '0, 0, 0, "wrap.last");
        cyc(0, '0, 0, 0, "wrap.idle");

        // Push during the final READ cycle leaves the held word alone.
        cyc(1, 32'hCAFE0001, 0, 0, "hold.p");
        cyc(0, '0, 1, 0, "hold.r1");
        drive(1, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        chk("hold.bus", pif.in_port_data_out, 32'hCAFE0001);
        @(posedge clk);
        model_edge();
        #1;
        chk("hold.avail", 32'(pif.data_avail), 32'h1);
        drive(0, '0, 1, 0);
        @(negedge clk);
        chk("hold.next", pif.in_port_data_out, 32'hDEADBEEF);
        @(posedge clk);
        model_edge();
        #1;
        cyc(0, '0, 0, 0, "hold.end");
        cyc(0, '0, 0, 0, "hold.idle");

        // Asynchronous clear in the middle of a read with two entries.
        cyc(1, 32'h0000_0066, 0, 0, "clr.p0");
        cyc(1, 32'h0000_0067, 0, 0, "clr.p1");
        cyc(0, '0, 1, 0, "clr.r");
        drive(0, '0, 1, 0);
        #2 clr = 1'b1;
        #1;
        chk("clr.ready", 32'(pif.ext_ready), 32'h1);
        chk("clr.avail", 32'(pif.data_avail), 32'h0);
        chk("clr.uf", 32'(pif.underflow), 32'h0);
        chk("clr.bus", pif.in_port_data_out, 32'h0);
        @(posedge clk);
        #1;
        drive(0, '0, 0, 0);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cyc(0, '0, 0, 0, "clr.idle");
        cyc(1, 32'h0000_0077, 0, 0, "clr.push");
        drive(0, '0, 1, 0);
        @(negedge clk);
        chk("clr.word", pif.in_port_data_out, 32'h0000_0077);
        @(posedge clk);
        model_edge();
        #1;
        cyc(0, '0, 0, 0, "clr.rel");
        cyc(0, '0, 0, 0, "clr.after");

        // Random traffic, reads held for random lengths.
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 1)), $urandom,
                bit'(($urandom % 3) != 0), bit'(($urandom % 8) == 0),
                $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
